qr_bist_sequencer: RTL and testbench
====================================

QR_BIST_SEQUENCER -- requirements
Module: qr_bist_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 48, meaning stimulus word width.
REQ-002 SHALL have parameter GROUP_LEN, default 200, meaning stimulus words per group (10 RE).
REQ-003 SHALL have parameter OUTS_PER_GROUP, default 10, meaning DUT results expected per group.
REQ-004 SHALL have parameter NUM_GROUPS, default 100, meaning groups per run.
REQ-005 SHALL have parameters R_W, default 320, and Y_W, default 160, meaning R and y_hat result widths.
REQ-006 SHALL have ports, with clock and reset first:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle run request, honoured in IDLE only.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse at end of run.
- o_pass  out  1  final verdict; valid while o_done=1 and held until the next start.
- o_err_cnt  out  16  saturating mismatch count.
- o_timeout  out  1  sticky watchdog flag.
- o_stim_addr  out  clog2(GROUP_LEN*NUM_GROUPS)  stimulus ROM address.
- i_stim_data  in  DATA_W  stimulus ROM data, 1-cycle read latency.
- o_dut_trig  out  1  DUT input valid (i_trig).
- o_dut_data  out  DATA_W  DUT input word.
- i_dut_rd_vld  in  1  DUT result valid.
- i_dut_last_data  in  1  DUT last result of group.
- i_dut_r  in  R_W  DUT R result.
- i_dut_y_hat  in  Y_W  DUT y_hat result.
- o_gold_addr  out  clog2(OUTS_PER_GROUP*NUM_GROUPS)  golden ROM address.
- i_gold_r  in  R_W  golden R, 1-cycle read latency.
- i_gold_y  in  Y_W  golden y_hat, 1-cycle read latency.

Function
REQ-007 SHALL implement the FSM IDLE->FETCH->SEND->WAIT_LAST->(FETCH | DONE)->IDLE.
REQ-008 IDLE SHALL move to FETCH on i_start=1 and SHALL clear o_err_cnt, o_timeout, the word index and the result index on that transition.
REQ-009 FETCH SHALL last exactly 1 cycle, issuing the group's first stimulus address.
REQ-010 SEND SHALL drive o_dut_trig=1 with consecutive stimulus words for exactly GROUP_LEN cycles, without gaps; the first word appears 2 cycles after i_start.
REQ-011 After the last word of a group, o_dut_trig SHALL fall to 0 and the FSM SHALL enter WAIT_LAST.
REQ-012 WAIT_LAST SHALL exit when i_dut_last_data=1, including i_dut_last_data seen during the final SEND cycle; exit goes to FETCH if groups remain, else DONE.
REQ-013 DONE SHALL last 1 cycle with o_done=1 and o_pass=(o_err_cnt==0 && !o_timeout); o_busy SHALL be 1 in every state except IDLE.
REQ-014 On each i_dut_rd_vld cycle, o_gold_addr SHALL equal the result index; the DUT r/y_hat SHALL be registered; the result index SHALL then increment.
REQ-015 The registered DUT result SHALL be compared with the golden data one cycle after i_dut_rd_vld; any bit difference in r or y_hat counts as one mismatch; o_err_cnt SHALL update 2 cycles after i_dut_rd_vld.
REQ-016 Back-to-back i_dut_rd_vld SHALL be compared at full rate, 1 result per cycle.
REQ-017 The per-group result count SHALL reset at each i_dut_last_data; if the count including that cycle is not equal to OUTS_PER_GROUP, one extra mismatch SHALL be counted.
REQ-018 o_err_cnt SHALL saturate at 16'hFFFF; i_dut_rd_vld outside a run SHALL be ignored.
REQ-019 i_start while o_busy=1 SHALL be ignored.

Reset
REQ-020 On i_rst_n=0, the FSM SHALL go to IDLE asynchronously, and all outputs and addresses SHALL be 0 (o_pass=0).
REQ-021 Reset mid-run SHALL abandon the run with no o_done pulse; the next i_start SHALL restart from group 0.

Configuration
REQ-022 With QR_BIST_TIMEOUT_EN defined, a 12-bit watchdog SHALL count WAIT_LAST cycles; at 4095 it SHALL set o_timeout and force DONE.
REQ-023 Without QR_BIST_TIMEOUT_EN, WAIT_LAST SHALL wait indefinitely and o_timeout SHALL be tied 0.

Structure
REQ-024 Package qr_bist_pkg SHALL hold the FSM state enum, default width/length constants and the watchdog limit.
REQ-025 Sub-module qr_bist_cmp SHALL hold the capture register, comparator and saturating counter.

Verification
REQ-026 GROUP_LEN=4, NUM_GROUPS=2, DUT asserts last_data 3 cycles after the last word -> trig high 4 cycles, low 3, then 4 again; o_done once; o_pass=1.
REQ-027 last_data coincident with the final SEND cycle -> next FETCH immediately, no idle trig gap beyond FETCH.
REQ-028 Golden result 5 corrupted in 1 bit of y_hat -> o_err_cnt=1 exactly 2 cycles after the 6th rd_vld; o_pass=0.
REQ-029 9 results before last_data, with OUTS_PER_GROUP=10 -> o_err_cnt=1.
REQ-030 Macro defined, last_data never asserted -> o_timeout=1 after 4095 WAIT_LAST cycles, o_done pulse, o_pass=0; macro undefined -> o_busy stays 1.
REQ-031 i_rst_n low mid-SEND -> all outputs 0 immediately; a new i_start re-reads stimulus address 0.

Source files
------------

// File: rtl/qr_bist_pkg.sv
// Shared types and constants for the QR BIST sequencer: FSM states, default
// geometry, counter widths, watchdog limit and a saturating-add helper.
package qr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_LAST = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int DEF_DATA_W     = 48;
  localparam int DEF_GROUP_LEN  = 200;
  localparam int DEF_OUTS       = 10;
  localparam int DEF_NUM_GROUPS = 100;
  localparam int DEF_R_W        = 320;
  localparam int DEF_Y_W        = 160;

  localparam int ERR_W = 16;
  localparam int CNT_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam int WD_W = 12;
  localparam logic [WD_W-1:0] WD_LIMIT = 12'd4095;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [1:0] b);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {{(ERR_W-1){1'b0}}, b};
    return s[ERR_W] ? ERR_MAX : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/qr_bist_sequencer_if.sv
// Result-side bus between the DUT/golden ROM and the comparator. The source
// (DUT model plus golden ROM) drives results and golden data; the comparator
// returns the golden ROM address.
interface qr_bist_sequencer_if #(
  parameter int R_W  = 320,
  parameter int Y_W  = 160,
  parameter int GA_W = 10
);
  logic            rd_vld;
  logic            last_data;
  logic [R_W-1:0]  r;
  logic [Y_W-1:0]  y_hat;
  logic [GA_W-1:0] gold_addr;
  logic [R_W-1:0]  gold_r;
  logic [Y_W-1:0]  gold_y;

  modport master (output rd_vld, last_data, r, y_hat, gold_r, gold_y,
                  input  gold_addr);
  modport slave  (input  rd_vld, last_data, r, y_hat, gold_r, gold_y,
                  output gold_addr);
endinterface

// File: rtl/qr_bist_cmp.sv
// Result checker: captures each valid DUT result, compares it with golden ROM
// data one cycle later, checks per-group result counts, keeps a saturating count.
module qr_bist_cmp
  import qr_bist_pkg::*;
#(
  parameter int R_W            = DEF_R_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int GA_W           = 10,
  parameter int OUTS_PER_GROUP = DEF_OUTS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_active,
  qr_bist_sequencer_if.slave res,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_clean
);

  logic             vld;
  logic             last;
  logic [GA_W-1:0]  ridx_q;
  logic [R_W-1:0]   cap_r_q;
  logic [Y_W-1:0]   cap_y_q;
  logic             cap_vld_q;
  logic [CNT_W-1:0] gcnt_q;
  logic [CNT_W-1:0] gcnt_incl;
  logic             cnt_bad_q;
  logic             mism;
  logic [1:0]       inc;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;

  assign vld       = res.rd_vld & i_active;
  assign last      = res.last_data & i_active;
  assign gcnt_incl = gcnt_q + CNT_W'(vld);

  // Golden ROM has one cycle of latency, so it lines up with the capture register.
  assign mism  = cap_vld_q && ((cap_r_q != res.gold_r) || (cap_y_q != res.gold_y));
  assign inc   = {1'b0, mism} + {1'b0, cnt_bad_q};
  assign err_d = sat_add(err_q, inc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ridx_q    <= '0;
      cap_r_q   <= '0;
      cap_y_q   <= '0;
      cap_vld_q <= 1'b0;
      gcnt_q    <= '0;
      cnt_bad_q <= 1'b0;
      err_q     <= '0;
    end else if (i_clear) begin
      ridx_q    <= '0;
      cap_vld_q <= 1'b0;
      gcnt_q    <= '0;
      cnt_bad_q <= 1'b0;
      err_q     <= '0;
    end else begin
      cap_vld_q <= vld;
      if (vld) begin
        cap_r_q <= res.r;
        cap_y_q <= res.y_hat;
        ridx_q  <= ridx_q + 1'b1;
      end
      if (last) begin
        gcnt_q    <= '0;
        cnt_bad_q <= (gcnt_incl != CNT_W'(OUTS_PER_GROUP));
      end else begin
        gcnt_q    <= gcnt_incl;
        cnt_bad_q <= 1'b0;
      end
      err_q <= err_d;
    end
  end

  assign res.gold_addr = ridx_q;
  assign o_err_cnt     = err_q;
  // Includes the mismatch still in flight so a verdict taken now is final.
  assign o_clean       = (err_q == '0) && (inc == 2'd0);

endmodule

// File: rtl/qr_bist_sequencer.sv
// BIST sequencer: streams stimulus groups into a QR DUT and checks its results
// against a golden ROM. Define QR_BIST_TIMEOUT_EN to enable the WAIT_LAST watchdog.
module qr_bist_sequencer
  import qr_bist_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int GROUP_LEN      = DEF_GROUP_LEN,
  parameter int OUTS_PER_GROUP = DEF_OUTS,
  parameter int NUM_GROUPS     = DEF_NUM_GROUPS,
  parameter int R_W            = DEF_R_W,
  parameter int Y_W            = DEF_Y_W,
  localparam int SA_W          = $clog2(GROUP_LEN*NUM_GROUPS),
  localparam int GA_W          = $clog2(OUTS_PER_GROUP*NUM_GROUPS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic              o_timeout,
  output logic [SA_W-1:0]   o_stim_addr,
  input  logic [DATA_W-1:0] i_stim_data,
  output logic              o_dut_trig,
  output logic [DATA_W-1:0] o_dut_data,
  input  logic              i_dut_rd_vld,
  input  logic              i_dut_last_data,
  input  logic [R_W-1:0]    i_dut_r,
  input  logic [Y_W-1:0]    i_dut_y_hat,
  output logic [GA_W-1:0]   o_gold_addr,
  input  logic [R_W-1:0]    i_gold_r,
  input  logic [Y_W-1:0]    i_gold_y
);

  localparam int SC_W = $clog2(GROUP_LEN+1);
  localparam int GR_W = $clog2(NUM_GROUPS+1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(GROUP_LEN-1);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(NUM_GROUPS-1);

  state_e          state_q, state_d;
  logic [SA_W-1:0] widx_q, widx_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [GR_W-1:0] grp_q, grp_d;
  logic            to_q, to_d;
  logic            pass_q, pass_d;
  logic            start_clr;
  logic            last_grp;
  logic            cmp_clean;
  logic            verdict;
`ifdef QR_BIST_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  qr_bist_sequencer_if #(.R_W(R_W), .Y_W(Y_W), .GA_W(GA_W)) res_if ();

  assign res_if.rd_vld    = i_dut_rd_vld;
  assign res_if.last_data = i_dut_last_data;
  assign res_if.r         = i_dut_r;
  assign res_if.y_hat     = i_dut_y_hat;
  assign res_if.gold_r    = i_gold_r;
  assign res_if.gold_y    = i_gold_y;
  assign o_gold_addr      = res_if.gold_addr;

  assign last_grp = (grp_q == GR_LAST);
  assign verdict  = cmp_clean & ~to_q;

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    sc_d      = sc_q;
    grp_d     = grp_q;
    to_d      = to_q;
    pass_d    = pass_q;
    start_clr = 1'b0;
`ifdef QR_BIST_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_FETCH;
          widx_d    = '0;
          sc_d      = '0;
          grp_d     = '0;
          to_d      = 1'b0;
          pass_d    = 1'b0;
          start_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_SEND;
        widx_d  = widx_q + 1'b1;
        sc_d    = '0;
      end
      ST_SEND: begin
        // The address runs one word ahead of the data to hide the ROM latency.
        if (sc_q == SC_LAST) begin
          if (i_dut_last_data) begin
            state_d = last_grp ? ST_DONE : ST_FETCH;
            grp_d   = grp_q + 1'b1;
          end else begin
            state_d = ST_WAIT_LAST;
          end
`ifdef QR_BIST_TIMEOUT_EN
          wd_d = '0;
`endif
        end else begin
          sc_d   = sc_q + 1'b1;
          widx_d = widx_q + 1'b1;
        end
      end
      ST_WAIT_LAST: begin
        if (i_dut_last_data) begin
          state_d = last_grp ? ST_DONE : ST_FETCH;
          grp_d   = grp_q + 1'b1;
        end
`ifdef QR_BIST_TIMEOUT_EN
        else if (wd_q == WD_LIMIT - 1'b1) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        pass_d  = verdict;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
      sc_q    <= '0;
      grp_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
`ifdef QR_BIST_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      sc_q    <= sc_d;
      grp_q   <= grp_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
`ifdef QR_BIST_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  qr_bist_cmp #(
    .R_W           (R_W),
    .Y_W           (Y_W),
    .GA_W          (GA_W),
    .OUTS_PER_GROUP(OUTS_PER_GROUP)
  ) u_cmp (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (start_clr),
    .i_active (o_busy),
    .res      (res_if.slave),
    .o_err_cnt(o_err_cnt),
    .o_clean  (cmp_clean)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = o_done ? verdict : pass_q;
  assign o_timeout   = to_q;
  assign o_stim_addr = widx_q;
  assign o_dut_trig  = (state_q == ST_SEND);
  assign o_dut_data  = o_dut_trig ? i_stim_data : '0;

endmodule

// File: tb/tb_qr_bist_sequencer.sv
// Directed bench for qr_bist_sequencer with a small geometry: 4 words per
// group, 2 groups, 3 results per group, stimulus word = 16'hA500 + address.
module tb_qr_bist_sequencer;

  localparam int DATA_W     = 16;
  localparam int GROUP_LEN  = 4;
  localparam int OUTS       = 3;
  localparam int NUM_GROUPS = 2;
  localparam int R_W        = 32;
  localparam int Y_W        = 16;
  localparam int SA_W       = 3;
  localparam int GA_W       = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, pass, timeout, trig;
  logic [15:0]       err_cnt;
  logic [SA_W-1:0]   stim_addr;
  logic [DATA_W-1:0] stim_data = '0;
  logic [DATA_W-1:0] dut_data;
  logic [R_W-1:0]    gold_r_mem [0:7];
  logic [Y_W-1:0]    gold_y_mem [0:7];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  qr_bist_sequencer_if #(.R_W(R_W), .Y_W(Y_W), .GA_W(GA_W)) res_if ();

  always #5 clk = ~clk;

  qr_bist_sequencer #(
    .DATA_W(DATA_W), .GROUP_LEN(GROUP_LEN), .OUTS_PER_GROUP(OUTS),
    .NUM_GROUPS(NUM_GROUPS), .R_W(R_W), .Y_W(Y_W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_busy         (busy),
    .o_done         (done),
    .o_pass         (pass),
    .o_err_cnt      (err_cnt),
    .o_timeout      (timeout),
    .o_stim_addr    (stim_addr),
    .i_stim_data    (stim_data),
    .o_dut_trig     (trig),
    .o_dut_data     (dut_data),
    .i_dut_rd_vld   (res_if.rd_vld),
    .i_dut_last_data(res_if.last_data),
    .i_dut_r        (res_if.r),
    .i_dut_y_hat    (res_if.y_hat),
    .o_gold_addr    (res_if.gold_addr),
    .i_gold_r       (res_if.gold_r),
    .i_gold_y       (res_if.gold_y)
  );

  // Synchronous ROM models, one cycle read latency.
  always @(posedge clk) stim_data <= 16'hA500 + 16'(stim_addr);
  always @(posedge clk) begin
    res_if.gold_r <= gold_r_mem[res_if.gold_addr];
    res_if.gold_y <= gold_y_mem[res_if.gold_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic drive_idle();
    start            = 1'b0;
    res_if.rd_vld    = 1'b0;
    res_if.last_data = 1'b0;
    res_if.r         = '0;
    res_if.y_hat     = '0;
  endtask

  task automatic put_res(input int idx, input logic lst);
    res_if.rd_vld    = 1'b1;
    res_if.r         = 32'h1000_0000 + 32'(idx);
    res_if.y_hat     = 16'h2000 + 16'(idx);
    res_if.last_data = lst;
  endtask

  // Group 0 delivers n0 results then last_data on its final SEND cycle;
  // group 1 delivers 3 results, the third together with last_data on its final SEND.
  task automatic run_tight(input int n0, input logic [15:0] err_done,
                           input logic [15:0] err_end, input logic exp_pass);
    int ridx;
    ridx = 0;
    cyc(); drive_idle(); start = 1'b1;
    cyc();
    chk("fetch0_busy", busy, 1);
    chk("fetch0_trig", trig, 0);
    chk("fetch0_addr", stim_addr, 0);
    chk("fetch0_gaddr", res_if.gold_addr, 0);
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t_g0_trig", trig, 1);
      chk("t_g0_data", dut_data, 16'hA500 + k);
      drive_idle();
      if (k < n0) begin put_res(ridx, 1'b0); ridx++; end
      if (k == 3) res_if.last_data = 1'b1;
    end
    cyc();
    chk("t_gap_trig", trig, 0);
    chk("t_gap_addr", stim_addr, 4);
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t_g1_trig", trig, 1);
      chk("t_g1_data", dut_data, 16'hA504 + k);
      drive_idle();
      if (k == 0 || k == 1 || k == 3) begin put_res(ridx, k == 3); ridx++; end
    end
    cyc();
    chk("t_done", done, 1);
    chk("t_done_pass", pass, exp_pass);
    chk("t_done_err", err_cnt, err_done);
    drive_idle();
    cyc();
    chk("t_end_busy", busy, 0);
    chk("t_end_pass", pass, exp_pass);
    chk("t_end_err", err_cnt, err_end);
  endtask

  initial begin
    int dseen;
    for (int i = 0; i < 8; i++) begin
      gold_r_mem[i] = 32'h1000_0000 + 32'(i);
      gold_y_mem[i] = 16'h2000 + 16'(i);
    end
    drive_idle();
    rst_n = 1'b0;

    // Reset state
    repeat (2) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_trig", trig, 0);
    chk("rst_data", dut_data, 0);
    chk("rst_saddr", stim_addr, 0);
    chk("rst_gaddr", res_if.gold_addr, 0);
    rst_n = 1'b1;

    // Two groups with last_data on the second cycle after each final word:
    // trig high 4, low 3 (two WAIT_LAST + FETCH), high 4. A start pulse mid-SEND is ignored.
    done_seen = 0;
    cyc(); drive_idle(); start = 1'b1;
    cyc();
    chk("a_fetch_busy", busy, 1);
    chk("a_fetch_trig", trig, 0);
    chk("a_fetch_addr", stim_addr, 0);
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("a_g0_trig", trig, 1);
      chk("a_g0_data", dut_data, 16'hA500 + k);
      drive_idle();
      if (k < 2) put_res(k, 1'b0);
      if (k == 2) start = 1'b1;
    end
    for (int w = 0; w < 2; w++) begin
      cyc();
      chk("a_wait0_trig", trig, 0);
      chk("a_wait0_busy", busy, 1);
      drive_idle();
      if (w == 1) put_res(2, 1'b1);
    end
    cyc();
    chk("a_fetch1_trig", trig, 0);
    chk("a_fetch1_addr", stim_addr, 4);
    chk("a_fetch1_gaddr", res_if.gold_addr, 3);
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("a_g1_trig", trig, 1);
      chk("a_g1_data", dut_data, 16'hA504 + k);
      drive_idle();
      if (k < 2) put_res(3 + k, 1'b0);
    end
    for (int w = 0; w < 2; w++) begin
      cyc();
      chk("a_wait1_trig", trig, 0);
      chk("a_wait1_done", done, 0);
      drive_idle();
      if (w == 1) put_res(5, 1'b1);
    end
    cyc();
    chk("a_done", done, 1);
    chk("a_done_pass", pass, 1);
    drive_idle();
    cyc();
    chk("a_idle_busy", busy, 0);
    chk("a_idle_done", done, 0);
    chk("a_idle_err", err_cnt, 0);
    chk("a_done_once", done_seen, 1);

    // Results outside a run are ignored; the verdict is held.
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      res_if.rd_vld = 1'b1; res_if.r = 32'hDEAD_BEEF; res_if.y_hat = 16'hBAD0;
      res_if.last_data = 1'b1;
      cyc();
    end
    drive_idle();
    cyc(); cyc();
    chk("idle_rd_gaddr", res_if.gold_addr, 6);
    chk("idle_rd_err", err_cnt, 0);
    chk("idle_pass_held", pass, 1);

    // last_data coincident with the final SEND cycle -> straight to FETCH.
    run_tight(3, 16'd0, 16'd0, 1'b1);

    // Golden result 5 corrupted in one y_hat bit -> err appears 2 cycles after the 6th rd_vld.
    gold_y_mem[5] = 16'h2004;
    run_tight(3, 16'd0, 16'd1, 1'b0);
    gold_y_mem[5] = 16'h2005;

    // One result short in group 0 -> one count mismatch.
    run_tight(2, 16'd1, 16'd1, 1'b0);

    // Reset in the middle of SEND.
    cyc(); drive_idle(); start = 1'b1;
    cyc(); drive_idle();
    put_res(0, 1'b0); res_if.y_hat = 16'hDEAD;
    cyc(); drive_idle();
    cyc();
    chk("r_pre_err", err_cnt, 1);
    chk("r_pre_trig", trig, 1);
    chk("r_pre_data", dut_data, 16'hA501);
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_trig", trig, 0);
    chk("r_data", dut_data, 0);
    chk("r_saddr", stim_addr, 0);
    chk("r_gaddr", res_if.gold_addr, 0);
    chk("r_err", err_cnt, 0);
    chk("r_done", done, 0);
    chk("r_pass", pass, 0);
    chk("r_timeout", timeout, 0);
    dseen = done_seen;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("r_no_done", done_seen, dseen);
    chk("r_idle_busy", busy, 0);
    run_tight(3, 16'd0, 16'd0, 1'b1);

    // last_data never arrives.
    cyc(); drive_idle(); start = 1'b1;
    cyc(); drive_idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("h_trig", trig, 1);
    end
`ifdef QR_BIST_TIMEOUT_EN
    begin
      int wcnt;
      wcnt = 0;
      for (int i = 0; i < 5000; i++) begin
        cyc();
        if (done === 1'b1) break;
        wcnt++;
      end
      chk("h_to_done", done, 1);
      chk("h_to_flag", timeout, 1);
      chk("h_to_pass", pass, 0);
      chk("h_to_cycles", wcnt, 4095);
      cyc();
      chk("h_to_sticky", timeout, 1);
      chk("h_to_idle", busy, 0);
    end
`else
    repeat (300) cyc();
    chk("h_hold_busy", busy, 1);
    chk("h_hold_trig", trig, 0);
    chk("h_hold_timeout", timeout, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
